// File: rtl/uart_tx.sv
// 8N1 UART transmitter: accepts a byte over valid/ready and shifts it out LSB first
// on a registered, glitch-free serial line that idles high.
module uart_tx #(
  parameter int CLK_FREQ  = 200_000_000,
  parameter int BAUD_RATE = 9600,
  parameter int D_WIDTH   = 8
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic [D_WIDTH-1:0] tx_data,
  input  logic               tx_valid,
  output logic               tx_ready,
  output logic               tx,
  output logic               tx_busy,
  output logic               tx_done
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
  localparam int BW       = $clog2(D_WIDTH) + 1;

  localparam logic [14:0]   BAUD_LAST = 15'(BAUD_DIV - 1);
  localparam logic [14:0]   BAUD_ONE  = 15'd1;
  localparam logic [14:0]   BAUD_ZERO = 15'd0;
  localparam logic [BW-1:0] BIT_LAST  = BW'(D_WIDTH - 1);
  localparam logic [BW-1:0] BIT_ONE   = BW'(1);
  localparam logic [BW-1:0] BIT_ZERO  = BW'(0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t             state_r;
  logic [14:0]        baud_cnt_r;
  logic [BW-1:0]      bit_cnt_r;
  logic [D_WIDTH-1:0] shift_r;

  // Frame sequencer: bit timing, shift register and all registered outputs.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r    <= IDLE;
      baud_cnt_r <= BAUD_ZERO;
      bit_cnt_r  <= BIT_ZERO;
      shift_r    <= '0;
      tx         <= 1'b1;
      tx_ready   <= 1'b1;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state_r)
        IDLE: begin
          baud_cnt_r <= BAUD_ZERO;
          if (tx_valid && tx_ready) begin
            shift_r  <= tx_data;
            state_r  <= START;
            tx       <= 1'b0;
            tx_ready <= 1'b0;
            tx_busy  <= 1'b1;
          end else begin
            tx <= 1'b1;
          end
        end
        START: begin
          if (baud_cnt_r == BAUD_LAST) begin
            baud_cnt_r <= BAUD_ZERO;
            bit_cnt_r  <= BIT_ZERO;
            state_r    <= DATA;
            tx         <= shift_r[0];
          end else begin
            baud_cnt_r <= baud_cnt_r + BAUD_ONE;
          end
        end
        DATA: begin
          if (baud_cnt_r == BAUD_LAST) begin
            baud_cnt_r <= BAUD_ZERO;
            if (bit_cnt_r == BIT_LAST) begin
              state_r <= STOP;
              tx      <= 1'b1;
            end else begin
              // Next wire bit is the one that becomes the LSB after this shift.
              shift_r   <= {1'b0, shift_r[D_WIDTH-1:1]};
              bit_cnt_r <= bit_cnt_r + BIT_ONE;
              tx        <= shift_r[1];
            end
          end else begin
            baud_cnt_r <= baud_cnt_r + BAUD_ONE;
          end
        end
        STOP: begin
          if (baud_cnt_r == BAUD_LAST) begin
            baud_cnt_r <= BAUD_ZERO;
            state_r    <= IDLE;
            tx_ready   <= 1'b1;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b1;
          end else begin
            baud_cnt_r <= baud_cnt_r + BAUD_ONE;
          end
        end
        default: begin
          state_r    <= IDLE;
          baud_cnt_r <= BAUD_ZERO;
          bit_cnt_r  <= BIT_ZERO;
          tx         <= 1'b1;
          tx_ready   <= 1'b1;
          tx_busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
